// File: rtl/axis_lfsr_checker.sv
// axis_lfsr_checker
// Receiving end of the 8-bit LFSR loopback. It locks onto the first beat
// after enable or clear, predicts every following beat with the same shift
// rule as the generator, and counts received and mismatching beats. An
// AXI-Lite slave exposes control (enable, clear, locked), the tap mask and
// both saturating counters.
module axis_lfsr_checker #(
   parameter int C_AXIL_ADDR_WIDTH = 4,
   parameter int C_AXIL_DATA_WIDTH = 32
) (
   input  logic                         aclk,
   input  logic                         areset,

   // AXI-Lite write address channel
   input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   // AXI-Lite write data channel (full-word writes only)
   input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   // AXI-Lite write response channel
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   // AXI-Lite read address channel
   input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                         s_axi_arvalid,
   output logic                         s_axi_arready,
   // AXI-Lite read data channel
   output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                   s_axi_rresp,
   output logic                         s_axi_rvalid,
   input  logic                         s_axi_rready,

   // LFSR stream input
   input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready
);

   // Register map (decode on the low four address bits)
   localparam logic [3:0] ADDR_CTRL = 4'h0;
   localparam logic [3:0] ADDR_TAPS = 4'h4;
   localparam logic [3:0] ADDR_BEAT = 4'h8;
   localparam logic [3:0] ADDR_ERR  = 4'hC;

   localparam logic [7:0]                   TAPS_RESET  = 8'h8E;
   localparam logic [C_AXIL_DATA_WIDTH-1:0] UNMAPPED    = 32'hDEADBEEF;
   localparam logic [C_AXIL_DATA_WIDTH-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // Shared shift rule with the generator: shift left, feedback is the
   // parity of the bits selected by the tap mask.
   function automatic logic [7:0] lfsr_next(input logic [7:0] x,
                                            input logic [7:0] taps);
      return {x[6:0], ^(x & taps)};
   endfunction

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   // Write channel
   logic                   awready_q;
   logic                   wready_q;
   logic                   aw_held_q;
   logic                   w_held_q;
   logic [3:0]             awaddr_q;
   logic [7:0]             wdata_q;
   logic                   bvalid_q;

   // Read channel
   logic                         arready_q;
   logic                         rvalid_q;
   logic [C_AXIL_DATA_WIDTH-1:0] rdata_q;

   // Configuration
   logic                   enable_q;
   logic [7:0]             taps_q;

   // Checker core
   state_t                       state_q;
   logic                         tready_q;
   logic [7:0]                   expected_q;
   logic [C_AXIL_DATA_WIDTH-1:0] beat_cnt_q;
   logic [C_AXIL_DATA_WIDTH-1:0] err_cnt_q;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic                         wr_commit;
   logic                         wr_ctrl;
   logic                         clear_pulse;
   logic                         beat_acc;
   logic                         beat_err;
   logic [7:0]                   lfsr_seed;
   logic [7:0]                   expected_d;
   logic [C_AXIL_DATA_WIDTH-1:0] beat_cnt_d;
   logic [C_AXIL_DATA_WIDTH-1:0] err_cnt_d;
   logic [C_AXIL_DATA_WIDTH-1:0] rd_mux;
   logic                         unused_wdata_bits;

   // Only the tap byte and control bits of a write are ever stored.
   assign unused_wdata_bits = ^s_axi_wdata[C_AXIL_DATA_WIDTH-1:8];

   // Both halves held: the register update happens on this edge.
   assign wr_commit   = aw_held_q & w_held_q;
   assign wr_ctrl     = wr_commit & (awaddr_q == ADDR_CTRL);
   assign clear_pulse = wr_ctrl & wdata_q[1];

   assign beat_acc = s_axis_tvalid & tready_q;
   assign beat_err = (s_axis_tdata[7:0] != expected_q) |
                     (|s_axis_tdata[C_AXIL_DATA_WIDTH-1:8]);

   // In SYNC the received byte seeds the predictor; afterwards the
   // prediction free-runs from its own previous value (no relock on data).
   assign lfsr_seed  = (state_q == ST_SYNC) ? s_axis_tdata[7:0] : expected_q;
   assign expected_d = lfsr_next(lfsr_seed, taps_q);

   // Saturating increments
   assign beat_cnt_d = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;
   assign err_cnt_d  = (err_cnt_q  == CNT_MAX) ? err_cnt_q  : err_cnt_q  + 1'b1;

   // Read data selection from the address presented on the AR channel
   always_comb begin
      rd_mux = UNMAPPED;
      unique case (s_axi_araddr[3:0])
         ADDR_CTRL: rd_mux = {{(C_AXIL_DATA_WIDTH-3){1'b0}},
                              (state_q == ST_CHECK), 1'b0, enable_q};
         ADDR_TAPS: rd_mux = {{(C_AXIL_DATA_WIDTH-8){1'b0}}, taps_q};
         ADDR_BEAT: rd_mux = beat_cnt_q;
         ADDR_ERR:  rd_mux = err_cnt_q;
         default:   rd_mux = UNMAPPED;
      endcase
   end

   // ------------------------------------------------------------------
   // AXI-Lite write: capture AW and W independently, commit once both are
   // held, then hold the response until the master takes it.
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         bvalid_q  <= 1'b0;
      end else begin
         if (s_axi_awvalid && awready_q) begin
            awaddr_q  <= s_axi_awaddr[3:0];
            aw_held_q <= 1'b1;
            awready_q <= 1'b0;
         end
         if (s_axi_wvalid && wready_q) begin
            wdata_q  <= s_axi_wdata[7:0];
            w_held_q <= 1'b1;
            wready_q <= 1'b0;
         end
         if (wr_commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
         end
         // Readies stay low through the response so only one write is open.
         if (bvalid_q && s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
         end
      end
   end

   // Configuration registers; RO and unmapped addresses are simply ignored.
   always_ff @(posedge aclk) begin
      if (areset) begin
         enable_q <= 1'b0;
         taps_q   <= TAPS_RESET;
      end else if (wr_commit) begin
         if (awaddr_q == ADDR_CTRL) begin
            enable_q <= wdata_q[0];
         end
         if (awaddr_q == ADDR_TAPS) begin
            taps_q <= wdata_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // AXI-Lite read: one outstanding read, data registered at AR handshake
   // and held until R handshake.
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else if (s_axi_arvalid && arready_q) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b1;
         rdata_q   <= rd_mux;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_q  <= 1'b0;
         arready_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Checker FSM, counters and predictor. Clear takes priority over a beat
   // on the same edge: the beat is dropped and the FSM re-syncs.
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         tready_q   <= 1'b0;
         expected_q <= '0;
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else if (clear_pulse) begin
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
         // The same write may also drop enable; honour that immediately so
         // tready falls one cycle after the write edge.
         if ((state_q != ST_IDLE) && wdata_q[0]) begin
            state_q  <= ST_SYNC;
            tready_q <= 1'b1;
         end else begin
            state_q  <= ST_IDLE;
            tready_q <= 1'b0;
         end
      end else begin
         if (beat_acc && (state_q != ST_IDLE)) begin
            beat_cnt_q <= beat_cnt_d;
            expected_q <= expected_d;
            if ((state_q == ST_CHECK) && beat_err) begin
               err_cnt_q <= err_cnt_d;
            end
         end

         unique case (state_q)
            ST_IDLE: begin
               if (enable_q) begin
                  state_q  <= ST_SYNC;
                  tready_q <= 1'b1;
               end
            end
            ST_SYNC: begin
               if (!enable_q) begin
                  state_q  <= ST_IDLE;
                  tready_q <= 1'b0;
               end else if (beat_acc) begin
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!enable_q) begin
                  state_q  <= ST_IDLE;
                  tready_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               tready_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign s_axis_tready = tready_q;

endmodule

// File: doc/axis_lfsr_checker.md
# axis_lfsr_checker

- AXI-Stream slave that receives the 8-bit LFSR sequence carried in 32-bit beats and checks it against a locally predicted sequence.
- Counts received beats and mismatching beats; configuration and status are exposed through an AXI-Lite slave register file.
- Sits at the receiving end of the LFSR stream as the loopback/checker partner of the generator; uses the same tap register convention and shift rule.

## Interface
- C_AXIL_ADDR_WIDTH, 4: AXI-Lite address width; decode uses bits [3:0].
- C_AXIL_DATA_WIDTH, 32: AXI-Lite and AXI-Stream data width.
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axi_awaddr / s_axi_awvalid / s_axi_awready  in/in/out  ADDR/1/1  write address channel.
- s_axi_wdata / s_axi_wvalid / s_axi_wready  in/in/out  DATA/1/1  write data channel; no strobes, full-word writes.
- s_axi_bresp / s_axi_bvalid / s_axi_bready  out/out/in  2/1/1  write response.
- s_axi_araddr / s_axi_arvalid / s_axi_arready  in/in/out  ADDR/1/1  read address.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid / s_axi_rready  out/out/out/in  DATA/2/1/1  read data.
- s_axis_tdata / s_axis_tvalid / s_axis_tready  in/in/out  DATA/1/1  LFSR stream input.

## Operation
- Registers: 0x0 CTRL (RW): bit0 enable; bit1 clear (write-1 pulse, self-clearing, reads 0); bit2 locked (RO, 1 when FSM in CHECK). 0x4 TAPS (RW) [7:0], reset 0x8E. 0x8 BEAT_COUNT (RO, 32-bit). 0xC ERR_COUNT (RO, 32-bit). Unmapped reads return 0xDEADBEEF; unmapped or RO writes are ignored. bresp/rresp always 2'b00.
- LFSR step: next(x) = {x[6:0], ^(x & TAPS)}.
- FSM IDLE: tready=0. enable=1 -> SYNC.
- FSM SYNC: tready=1. First accepted beat: expected <= next(tdata[7:0]); BEAT_COUNT+1; no compare -> CHECK.
- FSM CHECK: tready=1. Each accepted beat: error if tdata[7:0] != expected or tdata[31:8] != 0; BEAT_COUNT+1, ERR_COUNT+1 on error; expected <= next(expected) always (no relock on data).
- enable=0 from SYNC/CHECK -> IDLE; counters and TAPS retained.
- clear in SYNC/CHECK -> SYNC; clear in IDLE stays IDLE; both counters zeroed.
- Counters saturate at 0xFFFFFFFF.
- AXI-Lite write: awready and wready independently high when that half is not yet captured and bvalid=0; each drops after its handshake. Register update and bvalid=1 on the cycle after both halves are held; bvalid holds until bready, then both readies return high. One outstanding write.
- AXI-Lite read: arready=1 when no read pending; after AR handshake, rdata registered and rvalid=1 next cycle; held stable until rready; arready returns high the cycle after the R handshake.

## Timing
- Reset values: all readies 0 except awready=1, wready=1, arready=1; bvalid=0, rvalid=0, bresp=rresp=0, rdata=0, s_axis_tready=0; FSM IDLE; enable=0; TAPS=0x8E; counters 0.
- tready is registered from FSM state: rises 1 cycle after the CTRL write edge that sets enable; falls 1 cycle after the edge that clears it; beats offered while tready=0 are not consumed.
- Beat accepted on edge with tvalid & tready; counters visible in reads issued on the following cycle.
- Clear coincident with an accepted beat: clear wins; counters 0, beat not counted, FSM SYNC.
- TAPS write mid-CHECK: the new taps apply to the first next() evaluated after the write edge.
- Read of a counter on the same edge it increments returns the pre-increment value.
- Reset asserted mid-transaction: all channels abort to reset values next edge; no response for the pending write or read.
- Simultaneous read and write are independent; no ordering between them.

## Test plan
- Reset then read all 4 addresses -> 0x0, 0x8E, 0x0, 0x0; read 0x10 (aliases 0x0 with 4-bit decode) -> 0x0.
- Enable, send 0x01,0x02,0x05,0x0B,0x16 -> BEAT_COUNT=5, ERR_COUNT=0, CTRL reads 0x5.
- Enable, send 0x01,0x02,0xFF,0x0B,0x16 -> BEAT_COUNT=5, ERR_COUNT=1.
- Send 0x01,0x02,0x00010005 -> ERR_COUNT=1 (upper-bit error).
- tvalid high while enable=0 -> tready stays 0, BEAT_COUNT=0; write clear during a beat burst -> counters 0, locked=0 until next beat.
- bready/rready held low 10 cycles -> bvalid/rvalid and rdata stable; no second write accepted until B completes.
